// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg: shared constants and FSM state type for the PWM capture block
// Contents: default CNT_W / TIMEOUT / NOM_PERIOD and the IDLE/HIGH/LOW state enum.
package pwm_cap_pkg;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 512;
    localparam int NOM_PERIOD = 256;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus registered rise/fall detector
// Ports: clk, rst (sync, active-low), pin (async input),
//        level (synced level), rise/fall (1-cycle pulses, 3 cycles after pin change).
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic       rise_q, rise_d, fall_q, fall_d;
    logic [2:0] warm_q, warm_d;
    // Edges are suppressed until the pipeline holds real pin data, so a pin
    // that is already high at reset release does not look like a fresh rise.
    always_comb begin
        s1_d   = pin;
        s2_d   = s1_q;
        s3_d   = s2_q;
        warm_d = {warm_q[1:0], 1'b1};
        rise_d = warm_q[2] & s2_q & ~s3_q;
        fall_d = warm_q[2] & ~s2_q & s3_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            warm_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            warm_q <= warm_d;
        end
    end
    assign level = s3_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time, period and duty with a valid/ready output
// Ports: clk, rst (sync, active-low), pwm_in (async pin), meas_ready (consumer accept),
//        meas_valid, high_count, period, duty, static_lvl, period_err, overrun (sticky).
module pwm_capture #(
    parameter int CNT_W      = pwm_cap_pkg::CNT_W,
    parameter int TIMEOUT    = pwm_cap_pkg::TIMEOUT,
    parameter int NOM_PERIOD = pwm_cap_pkg::NOM_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       duty,
    output logic             static_lvl,
    output logic             period_err,
    output logic             overrun
);
    import pwm_cap_pkg::*;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] NOM     = CNT_W'(NOM_PERIOD);
    localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(255);
    logic             lvl, rise, fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, to_q, to_d;
    logic             valid_q, valid_d, stat_q, stat_d, perr_q, perr_d, ovr_q, ovr_d;
    logic [CNT_W-1:0] high_q, high_d, per_q, per_d;
    logic [7:0]       duty_q, duty_d;
    logic             pub, pub_stat, pub_err, load, timeout;
    logic [CNT_W-1:0] pub_hi, pub_per;
    logic [7:0]       pub_duty;
    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (pwm_in),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        cnt_d    = rise ? CNT_W'(1) : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout  = !rise && !fall && to_q == TO_LAST;
        to_d     = (rise || fall || timeout) ? '0 : to_q + 1'b1;
        pub      = 1'b0;
        pub_stat = 1'b0;
        pub_hi   = '0;
        pub_per  = '0;
        pub_err  = 1'b0;
        pub_duty = 8'd0;
        if (timeout) begin
            pub      = 1'b1;
            pub_stat = 1'b1;
            pub_duty = lvl ? 8'hFF : 8'h00;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = rise ? HIGH : IDLE;
                HIGH: begin
                    state_d = fall ? LOW : HIGH;
                    hi_d    = fall ? cnt_q : hi_q;
                end
                LOW: begin
                    state_d  = rise ? HIGH : LOW;
                    pub      = rise;
                    pub_hi   = hi_q;
                    pub_per  = cnt_q;
                    pub_err  = cnt_q != NOM;
                    pub_duty = pub_err ? 8'd0 : (hi_q > DUTY_MAX) ? 8'hFF : hi_q[7:0];
                end
                default: state_d = IDLE;
            endcase
        end
        // A publish lands if the slot is free or is being handed off this cycle.
        load    = pub && (!valid_q || meas_ready);
        valid_d = load || (valid_q && !meas_ready);
        ovr_d   = ovr_q || (pub && valid_q && !meas_ready);
        high_d  = load ? pub_hi : high_q;
        per_d   = load ? pub_per : per_q;
        duty_d  = load ? pub_duty : duty_q;
        stat_d  = load ? pub_stat : stat_q;
        perr_d  = load ? pub_err : perr_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            to_q    <= '0;
            valid_q <= 1'b0;
            high_q  <= '0;
            per_q   <= '0;
            duty_q  <= 8'd0;
            stat_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            to_q    <= to_d;
            valid_q <= valid_d;
            high_q  <= high_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            stat_q  <= stat_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign meas_valid = valid_q;
    assign high_count = high_q;
    assign period     = per_q;
    assign duty       = duty_q;
    assign static_lvl = stat_q;
    assign period_err = perr_q;
    assign overrun    = ovr_q;
endmodule
